serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial sequencer that reuses one external single-bit full-adder cell (the team's gate-level `fulladder` netlist) to add two WIDTH-bit operands over WIDTH cycles.
- Owns operand shift registers, the carry flip-flop, the bit counter and the start/done handshake.
- Sits between a test/host interface and the full-adder datapath, so fault-simulated adder netlists run under a realistic sequential controller.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new addition; sampled only while ready=1
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- ready  output  1  controller idle and able to accept start
- busy  output  1  serial addition in progress
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  result; held until the next accepted start
- cout  output  1  final carry-out; held like sum
- fa_i0  output  1  to full-adder i0 (current bit of A)
- fa_i1  output  1  to full-adder i1 (current bit of B)
- fa_ci  output  1  to full-adder ci (carry register)
- fa_s  input  1  from full-adder s
- fa_co  input  1  from full-adder co

Behaviour:
- States: IDLE, RUN, DONE. State encoding lives in the package.
- Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, carry=0, count=0, shift registers=0, fa_i0/fa_i1/fa_ci=0.
- IDLE:
  - ready=1.
  - On start=1: load a_sr<=a, b_sr<=b, carry<=cin, count<=0, and go to RUN.
  - sum and cout keep their previous values.
- RUN:
  - busy=1, ready=0.
  - fa_i0=a_sr[0], fa_i1=b_sr[0], fa_ci=carry, all combinational from registers.
  - Each edge: sum_sr shifts right with fa_s entering at MSB; a_sr and b_sr shift right; carry<=fa_co; count<=count+1.
  - When count==WIDTH-1 at an edge: update sum<=final sum_sr (including this edge's fa_s), cout<=fa_co, and go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, ready=0.
  - Unconditionally returns to IDLE.
- fa_i0/fa_i1/fa_ci are forced to 0 outside RUN, giving deterministic fault-sim patterns.
- Latency: start accepted at edge k means RUN covers edges k+1..k+WIDTH and done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance. Next start can be accepted at edge k+WIDTH+2.
- start while busy or in DONE is ignored; there is no queuing and no error flag.
- a, b and cin changing during RUN have no effect.
- WIDTH=1: RUN lasts exactly one cycle and the counter compare is count==0.
- Counter width is $clog2(WIDTH) bits, minimum 1; the counter never wraps because it exits at WIDTH-1.
- Reset asserted mid-RUN: immediate return to reset values. The partial result is discarded and sum/cout are cleared to 0.
- No combinational path from start to any output except through state.

Decomposition:
- Package serial_adder_pkg holds:
  - state_t enum {IDLE, RUN, DONE};
  - function cnt_w(WIDTH) returning the counter width;
  - localparam MAX_WIDTH=64.
- The full-adder cell stays external and is connected by the parent/bench; no internal instance.
- One natural sub-module: serial_shift_reg (parameterised right-shift register with parallel load and serial-in). It is instantiated three times, for a_sr, b_sr and sum_sr.

Test Plan:
- Smoke test, WIDTH=8, bench wires a `fulladder` instance: a=0x5A, b=0x3C, cin=0 -> done pulses 9 cycles after start, sum=0x96, cout=0; fa_i0 sequence LSB-first is 0,1,0,1,1,0,1,0.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
- Handshake rules:
  - Pulse start every cycle during a RUN of a=0x01, b=0x01 -> exactly one done, sum=0x02.
  - Change a and b mid-RUN -> result unaffected.
  - Back-to-back: start held high -> second operation accepted at edge k+10, first in IDLE.
- Reset mid-operation: assert rst at RUN cycle 4 of a=0xAA, b=0x55 -> ready=1, sum=0, cout=0, fa_* = 0 immediately (asynchronously); a subsequent 0x10+0x20 yields 0x30.
- WIDTH=1 build: a=1, b=1, cin=1 -> done 2 cycles after start, sum=1, cout=1. Then 0+0+0 -> sum=0, cout=0.
- Datapath fault propagation: replace the adder with a model forcing fa_co=0 -> 0x0F+0x01 gives sum=0x0E, cout=0 (mismatch against the golden 0x10 is detected by the bench scoreboard).

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: one bit minimum so WIDTH=1 still has a compare target.
  function automatic int unsigned cnt_w(input int unsigned width);
    int unsigned w;
    w = (width > MAX_WIDTH) ? MAX_WIDTH : width;
    return (w <= 1) ? 1 : int'($clog2(w));
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shift register with parallel load and serial input at the MSB.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Shift form written so WIDTH=1 degenerates to sr_d = serial_in.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = (sr_q >> 1) | (WIDTH'(serial_in) << (WIDTH - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer driving an external single-bit full-adder cell.
//
//   state | meaning
//   IDLE  | ready, waiting for start; sum/cout hold last result
//   RUN   | one operand bit per cycle through the external adder
//   DONE  | one-cycle done pulse, then back to IDLE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_i0,
  output logic             fa_i1,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int unsigned      CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             sr_load, sr_shift;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_final;
  logic             in_run;
  logic             unused_sr;

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clk(clk), .rst(rst), .load(sr_load), .shift(sr_shift),
    .load_val(a), .serial_in(1'b0), .q(a_sr)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clk(clk), .rst(rst), .load(sr_load), .shift(sr_shift),
    .load_val(b), .serial_in(1'b0), .q(b_sr)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_sum_sr (
    .clk(clk), .rst(rst), .load(sr_load), .shift(sr_shift),
    .load_val('0), .serial_in(fa_s), .q(sum_sr)
  );

  // Value sum_sr takes on the final RUN edge, captured directly into sum.
  assign sum_final = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  // Operand registers only present bit 0 to the adder; upper bits feed the shift.
  assign unused_sr = ^{a_sr, b_sr};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_load = 1'b1;
          carry_d = cin;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sr_shift = 1'b1;
        carry_d  = fa_co;
        if (count_q == LAST) begin
          sum_d   = sum_final;
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_run = (state_q == RUN);
  assign ready  = (state_q == IDLE);
  assign busy   = in_run;
  assign done   = (state_q == DONE);
  assign sum    = sum_q;
  assign cout   = cout_q;

  // Adder inputs are held at zero outside RUN so fault-sim patterns stay deterministic.
  assign fa_i0 = in_run & a_sr[0];
  assign fa_i1 = in_run & b_sr[0];
  assign fa_ci = in_run & carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1) with a result scoreboard.
module tb_serial_adder_ctrl;

  typedef struct packed {
    logic       cout;
    logic [7:0] sum;
  } exp8_t;

  typedef struct packed {
    logic cout;
    logic sum;
  } exp1_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt8 = 0;

  exp8_t q8[$];
  exp1_t q1[$];
  exp8_t e8;
  exp1_t e1;

  logic       start8, cin8, ready8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       fa_i0_8, fa_i1_8, fa_ci_8, fa_s8, fa_co8;
  logic       fault_co;

  logic       start1, cin1, ready1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  logic       fa_i0_1, fa_i1_1, fa_ci_1, fa_s1, fa_co1;

  assign fa_s8  = fa_i0_8 ^ fa_i1_8 ^ fa_ci_8;
  assign fa_co8 = fault_co ? 1'b0 : ((fa_i0_8 & fa_i1_8) | (fa_ci_8 & (fa_i0_8 ^ fa_i1_8)));
  assign fa_s1  = fa_i0_1 ^ fa_i1_1 ^ fa_ci_1;
  assign fa_co1 = (fa_i0_1 & fa_i1_1) | (fa_ci_1 & (fa_i0_1 ^ fa_i1_1));

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_i0(fa_i0_8), .fa_i1(fa_i1_8), .fa_ci(fa_ci_8), .fa_s(fa_s8), .fa_co(fa_co8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .fa_i0(fa_i0_1), .fa_i1(fa_i1_1), .fa_ci(fa_ci_1), .fa_s(fa_s1), .fa_co(fa_co1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden add; with the carry path broken only cin reaches bit 0.
  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic nocarry);
    exp8_t      e;
    logic [8:0] t;
    if (nocarry) begin
      e.sum  = a ^ b ^ {7'd0, c};
      e.cout = 1'b0;
    end else begin
      t      = {1'b0, a} + {1'b0, b} + {8'd0, c};
      e.sum  = t[7:0];
      e.cout = t[8];
    end
    return e;
  endfunction

  function automatic exp1_t model1(input logic a, input logic b, input logic c);
    logic [1:0] t;
    t = {1'b0, a} + {1'b0, b} + {1'b0, c};
    return exp1_t'(t);
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      done_cnt8++;
      if (q8.size() == 0) begin
        check("sb8_underflow", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        check("sb8_sum", 64'(sum8), 64'(e8.sum));
        check("sb8_cout", 64'(cout8), 64'(e8.cout));
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        check("sb1_underflow", 64'd1, 64'd0);
      end else begin
        e1 = q1.pop_front();
        check("sb1_sum", 64'(sum1), 64'(e1.sum));
        check("sb1_cout", 64'(cout1), 64'(e1.cout));
      end
    end
  end

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input int mid_at, input logic [7:0] a_mid, input logic [7:0] b_mid,
                     output int lat, output logic [7:0] fa_seq);
    int idx;
    bit got;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(model8(a, b, c, fault_co));
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; idx = 0; got = 1'b0; fa_seq = '0;
    while (!got && lat < 30) begin
      if (busy8 && idx < 8) begin
        fa_seq[idx] = fa_i0_8;
        idx++;
      end
      if (mid_at != 0 && lat == mid_at) begin
        a8 = a_mid; b8 = b_mid; cin8 = ~c;
      end
      @(posedge clk); #1;
      lat++;
      if (done8) got = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic go1(input logic a, input logic b, input logic c, output int lat);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    q1.push_back(model1(a, b, c));
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int         lat;
    int         dc;
    logic [7:0] seq;

    rst = 1'b1; fault_co = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready8", 64'(ready8), 64'd1);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_sum8", 64'(sum8), 64'd0);
    check("rst_cout8", 64'(cout8), 64'd0);
    check("rst_fa8", 64'({fa_i0_8, fa_i1_8, fa_ci_8}), 64'd0);
    check("rst_ready1", 64'(ready1), 64'd1);
    check("rst_busy1", 64'(busy1), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    go8(8'h5A, 8'h3C, 1'b0, 0, 8'h00, 8'h00, lat, seq);
    check("smoke_lat", 64'(lat), 64'd8);
    check("smoke_fa_i0_seq", 64'(seq), 64'h5A);
    check("smoke_ready", 64'(ready8), 64'd1);

    go8(8'hFF, 8'h01, 1'b0, 0, 8'h00, 8'h00, lat, seq);
    go8(8'hFF, 8'h00, 1'b1, 0, 8'h00, 8'h00, lat, seq);
    go8(8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00, lat, seq);
    for (int i = 0; i < 4; i++) begin
      go8(8'($urandom), 8'($urandom), 1'($urandom), 0, 8'h00, 8'h00, lat, seq);
      check("rand_lat", 64'(lat), 64'd8);
    end

    // start held high for the whole RUN and DONE window
    dc = done_cnt8;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'h01, 8'h01, 1'b0, 1'b0));
    @(posedge clk); #1;
    for (int i = 1; i <= 9; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    check("pulse_done_cnt", 64'(done_cnt8 - dc), 64'd1);
    check("pulse_ready", 64'(ready8), 64'd1);
    @(posedge clk); #1;
    check("pulse_no_reaccept", 64'(busy8), 64'd0);

    go8(8'h33, 8'h44, 1'b0, 3, 8'hCC, 8'hBB, lat, seq);
    check("midrun_lat", 64'(lat), 64'd8);

    // back-to-back: second operation accepted at edge k+10
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'h12, 8'h34, 1'b0, 1'b0));
    @(posedge clk); #1;
    a8 = 8'h21; b8 = 8'h43; cin8 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
    end
    check("b2b_gap_ready", 64'(ready8), 64'd1);
    q8.push_back(model8(8'h21, 8'h43, 1'b1, 1'b0));
    @(posedge clk); #1;
    check("b2b_accept", 64'(busy8), 64'd1);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat2", 64'(lat), 64'd8);
    @(posedge clk); #1;

    // asynchronous reset partway through an addition
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rst_mid_busy", 64'(busy8), 64'd1);
    check("rst_mid_fa", 64'({fa_i0_8, fa_i1_8, fa_ci_8}), 64'b010);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ready", 64'(ready8), 64'd1);
    check("rst_mid_busy0", 64'(busy8), 64'd0);
    check("rst_mid_sum", 64'(sum8), 64'd0);
    check("rst_mid_cout", 64'(cout8), 64'd0);
    check("rst_mid_fa0", 64'({fa_i0_8, fa_i1_8, fa_ci_8}), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    go8(8'h10, 8'h20, 1'b0, 0, 8'h00, 8'h00, lat, seq);
    check("post_rst_lat", 64'(lat), 64'd8);

    // broken carry path in the adder cell
    fault_co = 1'b1;
    go8(8'h0F, 8'h01, 1'b0, 0, 8'h00, 8'h00, lat, seq);
    tests++;
    assert (sum8 !== 8'h10) else begin
      fails++;
      $error("FAIL fault_detect: observed 0x%0h equals golden 0x10", sum8);
    end
    fault_co = 1'b0;

    go1(1'b1, 1'b1, 1'b1, lat);
    check("w1_lat", 64'(lat), 64'd1);
    go1(1'b0, 1'b0, 1'b0, lat);
    check("w1_lat_zero", 64'(lat), 64'd1);
    go1(1'b1, 1'b0, 1'b0, lat);

    check("sb8_drained", 64'(q8.size()), 64'd0);
    check("sb1_drained", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
